// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared encodings between the CPU control FSM and datapath_core:
//   strobe bit positions for write_en/inc_en/clr_en, bus source codes
//   for read_en, and ALU operation codes.
package cpu_pkg;

    // Strobe bit positions (same map for write_en, inc_en and clr_en)
    localparam int WE_PC          = 1;
    localparam int WE_AR          = 2;
    localparam int WE_IR          = 3;
    localparam int WE_AC          = 4;
    localparam int WE_R           = 5;
    localparam int WE_R4          = 7;
    localparam int WE_R3          = 8;
    localparam int WE_R2          = 9;
    localparam int WE_R1          = 10;
    localparam int WE_DM          = 11;
    localparam int WE_AC_FROM_ALU = 12;
    localparam int WE_R_FROM_AC   = 13;

    // Bus source codes; unlisted codes drive zero
    typedef enum logic [3:0] {
        RD_NONE = 4'd0,
        RD_PC   = 4'd1,
        RD_AR   = 4'd2,
        RD_IR   = 4'd4,
        RD_AC   = 4'd5,
        RD_R    = 4'd6,
        RD_R1   = 4'd7,
        RD_R2   = 4'd8,
        RD_R3   = 4'd9,
        RD_R4   = 4'd10,
        RD_DM   = 4'd12,
        RD_IM   = 4'd13
    } rd_sel_e;

    // ALU operations; codes 5-7 behave as pass
    typedef enum logic [2:0] {
        ALU_PASS   = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_MULT   = 3'd3,
        ALU_LSHIFT = 3'd4
    } alu_op_e;

endpackage

// File: rtl/datapath_core_dp_reg.sv
// dp_reg
//   Generic datapath register with synchronous reset, clear, load and
//   increment. Priority: rst > clr > load > inc. Increment wraps.
// Ports
//   clk, rst    clock and synchronous active-high reset
//   clr/ld/inc  per-register strobes
//   d           load value
//   q           register contents
module dp_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = d;
        end else if (inc) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/datapath_core.sv
// datapath_core
//   Executes the per-state control word from the CPU control FSM. Holds
//   PC, AR, IR, AC, R and R1-R4 around a single shared bus, contains the
//   ALU and the registered zero flag, and returns opcode and zero flag.
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   alu_op                     ALU operation (cpu_pkg::alu_op_e)
//   write_en/inc_en/clr_en     load/increment/clear strobes (cpu_pkg map)
//   read_en                    bus source select (cpu_pkg::rd_sel_e)
//   im_rdata/dm_rdata          async-read memory data
//   im_addr/dm_addr            low ADDR_W bits of PC / AR
//   dm_wdata, dm_we            data memory write port (bus value)
//   instruction                IR opcode field
//   z                          16'd1 when zero flag set
//   bus_dbg                    current bus value
module datapath_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        alu_op,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [3:0]        read_en,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic [OP_W-1:0]   instruction,
    output logic [15:0]       z,
    output logic [DATA_W-1:0] bus_dbg
);

    function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   res;
        prod = a * b;
        case (op)
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_MULT:   res = prod[DATA_W-1:0];
            ALU_LSHIFT: res = {a[DATA_W-2:0], 1'b0};
            default:    res = a;
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] pc, ar, ir, r1, r2, r3, r4;
    logic [DATA_W-1:0] ac_q, ac_d, r_q, r_d;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] ir_operand;
    logic              zf_q, zf_d;
    logic              ac_touch;

    // Bits 0, 6, 14, 15 of the strobe words carry no function.
    logic unused_strobes;
    assign unused_strobes = ^{write_en[0], write_en[6], write_en[15:14],
                              inc_en[0], inc_en[6], inc_en[15:11], inc_en[3:2],
                              clr_en[0], clr_en[6], clr_en[15:11], clr_en[3:2],
                              inc_en[10:7], clr_en[10:7]};

    // Address field of IR, used by jump and ldiac
    assign ir_operand = {{OP_W{1'b0}}, ir[DATA_W-1:OP_W]};

    always_comb begin
        bus = '0;
        case (read_en)
            RD_PC:   bus = pc;
            RD_AR:   bus = ar;
            RD_IR:   bus = ir_operand;
            RD_AC:   bus = ac_q;
            RD_R:    bus = r_q;
            RD_R1:   bus = r1;
            RD_R2:   bus = r2;
            RD_R3:   bus = r3;
            RD_R4:   bus = r4;
            RD_DM:   bus = dm_rdata;
            RD_IM:   bus = im_rdata;
            default: bus = '0;
        endcase
    end

    assign alu_res = alu_fn(alu_op, ac_q, r_q);

    dp_reg #(.W(DATA_W)) u_pc (.clk(clk), .rst(rst), .clr(clr_en[WE_PC]),
        .ld(write_en[WE_PC]), .inc(inc_en[WE_PC]), .d(bus), .q(pc));
    dp_reg #(.W(DATA_W)) u_ar (.clk(clk), .rst(rst), .clr(clr_en[WE_AR]),
        .ld(write_en[WE_AR]), .inc(inc_en[WE_AR]), .d(bus), .q(ar));
    dp_reg #(.W(DATA_W)) u_ir (.clk(clk), .rst(rst), .clr(clr_en[WE_IR]),
        .ld(write_en[WE_IR]), .inc(inc_en[WE_IR]), .d(bus), .q(ir));
    dp_reg #(.W(DATA_W)) u_r1 (.clk(clk), .rst(rst), .clr(clr_en[WE_R1]),
        .ld(write_en[WE_R1]), .inc(inc_en[WE_R1]), .d(bus), .q(r1));
    dp_reg #(.W(DATA_W)) u_r2 (.clk(clk), .rst(rst), .clr(clr_en[WE_R2]),
        .ld(write_en[WE_R2]), .inc(inc_en[WE_R2]), .d(bus), .q(r2));
    dp_reg #(.W(DATA_W)) u_r3 (.clk(clk), .rst(rst), .clr(clr_en[WE_R3]),
        .ld(write_en[WE_R3]), .inc(inc_en[WE_R3]), .d(bus), .q(r3));
    dp_reg #(.W(DATA_W)) u_r4 (.clk(clk), .rst(rst), .clr(clr_en[WE_R4]),
        .ld(write_en[WE_R4]), .inc(inc_en[WE_R4]), .d(bus), .q(r4));

    // AC and R have two load sources each; the non-bus source wins.
    always_comb begin
        ac_d = ac_q;
        if (clr_en[WE_AC]) begin
            ac_d = '0;
        end else if (write_en[WE_AC_FROM_ALU]) begin
            ac_d = alu_res;
        end else if (write_en[WE_AC]) begin
            ac_d = bus;
        end else if (inc_en[WE_AC]) begin
            ac_d = ac_q + 1'b1;
        end

        r_d = r_q;
        if (clr_en[WE_R]) begin
            r_d = '0;
        end else if (write_en[WE_R_FROM_AC]) begin
            r_d = ac_q;
        end else if (write_en[WE_R]) begin
            r_d = bus;
        end else if (inc_en[WE_R]) begin
            r_d = r_q + 1'b1;
        end

        // Flag follows AC only on cycles that modify AC.
        ac_touch = clr_en[WE_AC] | write_en[WE_AC_FROM_ALU] |
                   write_en[WE_AC] | inc_en[WE_AC];
        zf_d = ac_touch ? (ac_d == '0) : zf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q <= '0;
            r_q  <= '0;
            zf_q <= 1'b1;
        end else begin
            ac_q <= ac_d;
            r_q  <= r_d;
            zf_q <= zf_d;
        end
    end

    assign im_addr     = pc[ADDR_W-1:0];
    assign dm_addr     = ar[ADDR_W-1:0];
    assign dm_wdata    = bus;
    assign dm_we       = write_en[WE_DM] & ~rst;
    assign instruction = ir[OP_W-1:0];
    assign z           = {15'd0, zf_q};
    assign bus_dbg     = bus;

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

    logic        clk;
    logic        rst;
    logic [2:0]  alu_op;
    logic [15:0] write_en, inc_en, clr_en;
    logic [3:0]  read_en;
    logic [15:0] im_rdata, dm_rdata;
    logic [9:0]  im_addr, dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [5:0]  instruction;
    logic [15:0] z;
    logic [15:0] bus_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    datapath_core dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .read_en(read_en),
        .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .instruction(instruction), .z(z), .bus_dbg(bus_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: register file indexed by strobe bit position.
    // Slots: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1
    logic [15:0] m [0:15];
    logic        m_zf;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_bus();
        int rd;
        rd = int'(read_en);
        case (rd)
            1:  return m[1];
            2:  return m[2];
            4:  return m[3] / 64;            // IR address field, zero-extended
            5:  return m[4];
            6:  return m[5];
            7:  return m[10];
            8:  return m[9];
            9:  return m[8];
            10: return m[7];
            12: return dm_rdata;
            13: return im_rdata;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] model_alu(input int op, input int a, input int b);
        int unsigned res;
        case (op)
            1: res = a + b;
            2: res = a - b;
            3: res = int'(a) * int'(b);
            4: res = a * 2;
            default: res = a;
        endcase
        return 16'(res % 65536);
    endfunction

    task automatic check_outputs();
        check_val("bus_dbg", bus_dbg, model_bus());
        check_val("dm_wdata", dm_wdata, model_bus());
        check_val("dm_we", {15'd0, dm_we}, {15'd0, write_en[11] & ~rst});
        check_val("im_addr", {6'd0, im_addr}, m[1] % 1024);
        check_val("dm_addr", {6'd0, dm_addr}, m[2] % 1024);
        check_val("instruction", {10'd0, instruction}, m[3] % 64);
        check_val("z", z, m_zf ? 16'd1 : 16'd0);
    endtask

    // One clock: apply control word, check outputs, advance model.
    task automatic step(input logic r, input logic [2:0] op, input logic [15:0] we,
                        input logic [15:0] inc, input logic [15:0] clr,
                        input logic [3:0] rd, input logic [15:0] imd, input logic [15:0] dmd);
        logic [15:0] nx [0:15];
        logic [15:0] b, src;
        logic        nzf;
        rst = r; alu_op = op; write_en = we; inc_en = inc; clr_en = clr;
        read_en = rd; im_rdata = imd; dm_rdata = dmd;
        #1;
        check_outputs();
        b = model_bus();
        nzf = m_zf;
        for (int i = 0; i < 16; i++) begin
            nx[i] = m[i];
            if (i == 1 || i == 2 || i == 3 || i == 4 || i == 5 || (i >= 7 && i <= 10)) begin
                src = b;
                if (i == 4 && we[12]) src = model_alu(int'(op), int'(m[4]), int'(m[5]));
                if (i == 5 && we[13]) src = m[4];
                if (clr[i])                                       nx[i] = 16'h0000;
                else if (we[i] || (i == 4 && we[12]) || (i == 5 && we[13])) nx[i] = src;
                else if (inc[i])                                  nx[i] = m[i] + 16'd1;
            end
        end
        if (clr[4] || we[4] || we[12] || inc[4]) nzf = (nx[4] == 16'h0000);
        if (r) begin
            for (int i = 0; i < 16; i++) nx[i] = 16'h0000;
            nzf = 1'b1;
        end
        @(posedge clk);
        for (int i = 0; i < 16; i++) m[i] = nx[i];
        m_zf = nzf;
        @(negedge clk);
    endtask

    // Observe one register through the bus without clocking.
    task automatic peek(input string tag, input logic [3:0] rd, input logic [15:0] exp);
        rst = 1'b0; write_en = '0; inc_en = '0; clr_en = '0; read_en = rd;
        #1;
        check_val(tag, bus_dbg, exp);
    endtask

    localparam logic [15:0] NONE = 16'h0000;

    initial begin
        for (int i = 0; i < 16; i++) m[i] = 16'h0000;
        m_zf = 1'b1;
        rst = 1'b1; alu_op = '0; write_en = '0; inc_en = '0; clr_en = '0;
        read_en = '0; im_rdata = '0; dm_rdata = '0;
        @(negedge clk);
        // Reset with every strobe active
        rst = 1'b1; write_en = 16'hFFFF; #1;
        check_val("rst_dm_we", {15'd0, dm_we}, 16'd0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 16; i++) m[i] = 16'h0000;
        m_zf = 1'b1;
        rst = 1'b0; write_en = '0; #1;
        check_val("rst_z", z, 16'd1);
        check_val("rst_instruction", {10'd0, instruction}, 16'd0);
        check_val("rst_im_addr", {6'd0, im_addr}, 16'd0);
        peek("rst_ac", 4'd5, 16'h0000);
        peek("rst_r1", 4'd7, 16'h0000);

        // Fetch
        step(0, 3'd0, 16'h0008, 16'h0002, NONE, 4'd13, 16'h0143, 16'h0);
        check_val("fetch_instr", {10'd0, instruction}, 16'd3);
        check_val("fetch_im_addr", {6'd0, im_addr}, 16'd1);
        peek("fetch_operand", 4'd4, 16'd5);
        // ldiac
        step(0, 3'd0, 16'h0004, NONE, NONE, 4'd4, 16'h0, 16'h0);
        check_val("ldiac_dm_addr", {6'd0, dm_addr}, 16'd5);
        step(0, 3'd0, 16'h0010, NONE, NONE, 4'd12, 16'h0, 16'h00AA);
        check_val("ldiac_z", z, 16'd0);
        peek("ldiac_ac", 4'd5, 16'h00AA);
        // ALU sub to zero
        step(0, 3'd0, 16'h0030, NONE, NONE, 4'd13, 16'h0007, 16'h0);
        step(0, 3'd2, 16'h1000, NONE, NONE, 4'd0, 16'h0, 16'h0);
        check_val("sub_z", z, 16'd1);
        peek("sub_ac", 4'd5, 16'h0000);
        // mult overflow
        step(0, 3'd0, 16'h0030, NONE, NONE, 4'd13, 16'h0100, 16'h0);
        step(0, 3'd3, 16'h1000, NONE, NONE, 4'd0, 16'h0, 16'h0);
        peek("mult_ac", 4'd5, 16'h0000);
        // lshift
        step(0, 3'd0, 16'h0010, NONE, NONE, 4'd13, 16'h8001, 16'h0);
        step(0, 3'd4, 16'h1000, NONE, NONE, 4'd0, 16'h0, 16'h0);
        peek("lshift_ac", 4'd5, 16'h0002);
        // clr beats inc
        step(0, 3'd0, NONE, 16'h0010, 16'h0010, 4'd0, 16'h0, 16'h0);
        peek("clr_inc_ac", 4'd5, 16'h0000);
        // load beats inc
        step(0, 3'd0, 16'h0002, 16'h0002, NONE, 4'd13, 16'h0020, 16'h0);
        peek("ld_inc_pc", 4'd1, 16'h0020);
        // inc wrap
        step(0, 3'd0, 16'h0010, NONE, NONE, 4'd13, 16'hFFFF, 16'h0);
        step(0, 3'd0, NONE, 16'h0010, NONE, 4'd0, 16'h0, 16'h0);
        peek("wrap_ac", 4'd5, 16'h0000);
        check_val("wrap_z", z, 16'd1);
        // ALU load beats bus load
        step(0, 3'd0, 16'h0010, NONE, NONE, 4'd13, 16'h0003, 16'h0);
        step(0, 3'd0, 16'h0020, NONE, NONE, 4'd13, 16'h0005, 16'h0);
        step(0, 3'd1, 16'h1010, NONE, NONE, 4'd13, 16'h0077, 16'h0);
        peek("alu_over_bus", 4'd5, 16'h0008);
        // stac
        step(0, 3'd0, 16'h0010, NONE, NONE, 4'd13, 16'h1234, 16'h0);
        step(0, 3'd0, 16'h0004, NONE, NONE, 4'd13, 16'h0009, 16'h0);
        rst = 0; write_en = 16'h0800; inc_en = '0; clr_en = '0; read_en = 4'd5; #1;
        check_val("stac_dm_we", {15'd0, dm_we}, 16'd1);
        check_val("stac_dm_wdata", dm_wdata, 16'h1234);
        check_val("stac_dm_addr", {6'd0, dm_addr}, 16'd9);
        step(0, 3'd0, 16'h0800, NONE, NONE, 4'd5, 16'h0, 16'h0);
        // jump
        step(0, 3'd0, 16'h0008, NONE, NONE, 4'd13, 16'h0283, 16'h0);
        step(0, 3'd0, 16'h0002, NONE, NONE, 4'd4, 16'h0, 16'h0);
        peek("jump_pc", 4'd1, 16'd10);
        step(1, 3'd0, 16'h0002, NONE, NONE, 4'd4, 16'h0, 16'h0);
        peek("jump_rst_pc", 4'd1, 16'd0);

        // Random control words against the reference model
        for (int k = 0; k < 600; k++) begin
            logic [15:0] imd;
            imd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            step(($urandom_range(0, 40) == 0),
                 3'($urandom),
                 16'($urandom & $urandom),
                 16'($urandom & $urandom),
                 16'($urandom & $urandom & $urandom & $urandom),
                 4'($urandom),
                 imd,
                 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
